// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//
// Pipeline MEM stage. It captures the EXE->MEM bus into a holding register and
// performs word data-memory accesses over a req/ready handshake. While an
// access is outstanding, the stage stalls the upstream pipeline and holds its
// register. A watchdog abandons any access that has waited MAX_WAIT stall
// cycles and reports the abort with a one-cycle dmem_err pulse.
//
// Ports
//   clk             system clock
//   rst_n           asynchronous active-low reset
//   exe_mem_bus_in  [154:0] {alu_result, rd_out, rd_wen, mem_we, mem_re,
//                   wb_sel, exe_pc, wb_data, csr_cmd, csr_addr, op1_data}
//   mem_wb_bus_out  [120:0] {wb_value, rd_out, rd_wen, wb_sel, exe_pc,
//                   csr_cmd, csr_addr, op1_data}
//   mem_stall       hold upstream pipeline registers
//   dmem_req        access request
//   dmem_we         1 = store, 0 = load
//   dmem_addr       word-aligned address {alu_result[31:2], 2'b00}
//   dmem_wdata      store data (wb_data field)
//   dmem_ready      access completes this cycle (rdata valid for loads)
//   dmem_rdata      load data
//   dmem_err        one-cycle pulse when the watchdog aborts an access
//   misalign_err    (MEM_MISALIGN_CHECK_EN only) pulses on a misaligned access
//
// Parameters
//   MAX_WAIT        stall cycles allowed per access before abort (1..65535)
//   CNT_W           wait counter width, 2**CNT_W > MAX_WAIT
//
// Build option
//   MEM_MISALIGN_CHECK_EN  when defined, accesses with alu_result[1:0] != 0
//                          are suppressed and flagged on misalign_err.
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [154:0] exe_mem_bus_in,
    output logic [120:0] mem_wb_bus_out,
    output logic         mem_stall,
    output logic         dmem_req,
    output logic         dmem_we,
    output logic [31:0]  dmem_addr,
    output logic [31:0]  dmem_wdata,
    input  logic         dmem_ready,
    input  logic [31:0]  dmem_rdata,
    output logic         dmem_err
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    output logic         misalign_err
`endif
);

    localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt_reg;
    logic [CNT_W-1:0] wait_cnt_next;
    logic [154:0]     mem_bus_r;

    // Field views of the held EXE->MEM bus
    logic [31:0] alu_result;
    logic [4:0]  rd_out;
    logic        rd_wen;
    logic        mem_we;
    logic        mem_re;
    logic [2:0]  wb_sel;
    logic [31:0] exe_pc;
    logic [31:0] wb_data;
    logic [3:0]  csr_cmd;
    logic [11:0] csr_addr;
    logic [31:0] op1_data;

    assign {alu_result, rd_out, rd_wen, mem_we, mem_re, wb_sel,
            exe_pc, wb_data, csr_cmd, csr_addr, op1_data} = mem_bus_r;

    logic        access;
    logic        misalign;
    logic        issue;
    logic        abort;
    logic [31:0] wb_value;
    logic        rd_wen_out;

    assign access = mem_we | mem_re;

`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign     = access & (alu_result[1:0] != 2'b00);
    assign misalign_err = misalign;
`else
    assign misalign = 1'b0;
`endif

    // A misaligned access never reaches memory; everything else is issued.
    assign issue = access & ~misalign;

    // Input register: frozen while the current access is still outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_bus_r <= '0;
        end else if (!mem_stall) begin
            mem_bus_r <= exe_mem_bus_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Handshake FSM. The IDLE cycle already counts as the first stall cycle,
    // so WAIT is entered with the counter at 1 and the abort fires on the
    // cycle after MAX_WAIT stall cycles have elapsed.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        dmem_req      = 1'b0;
        mem_stall     = 1'b0;
        abort         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (issue) begin
                    dmem_req = 1'b1;
                    if (!dmem_ready) begin
                        mem_stall     = 1'b1;
                        state_next    = WAIT;
                        wait_cnt_next = CNT_W'(1);
                    end
                end
            end
            WAIT: begin
                if (dmem_ready) begin
                    dmem_req      = 1'b1;
                    state_next    = IDLE;
                    wait_cnt_next = '0;
                end else if (wait_cnt_reg == MAX_WAIT_C) begin
                    // Request withdrawn in the abort cycle itself.
                    abort         = 1'b1;
                    state_next    = IDLE;
                    wait_cnt_next = '0;
                end else begin
                    dmem_req      = 1'b1;
                    mem_stall     = 1'b1;
                    wait_cnt_next = wait_cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next    = IDLE;
                wait_cnt_next = '0;
            end
        endcase
    end

    // Memory-side request fields come straight from the held register, so
    // they stay stable for the whole life of an access.
    assign dmem_we    = mem_we;
    assign dmem_addr  = {alu_result[31:2], 2'b00};
    assign dmem_wdata = wb_data;
    assign dmem_err   = abort;

    always_comb begin
        case (wb_sel)
            3'b010:  wb_value = dmem_rdata;
            3'b011:  wb_value = exe_pc + 32'd4;
            default: wb_value = alu_result;
        endcase
    end

    // WB sees a bubble during stalls, and nothing at all from aborted or
    // suppressed accesses.
    assign rd_wen_out = rd_wen & ~mem_stall & ~abort & ~misalign;

    assign mem_wb_bus_out = {wb_value, rd_out, rd_wen_out, wb_sel, exe_pc,
                             csr_cmd, csr_addr, op1_data};

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
//
// Self-checking bench for mem_stage (built with MAX_WAIT = 4). Each scenario
// task drives its own stimulus and compares outputs inline. Inputs change
// 2 time units after a rising edge and outputs are sampled 2 units later.
// The randomized scenario predicts every instruction from its ready delay:
// an access whose ready arrives on cycle d occupies min(d, MAX_WAIT)+1 cycles
// and is aborted when d exceeds MAX_WAIT.
// -----------------------------------------------------------------------------
module tb_mem_stage;

    localparam int MAX_WAIT = 4;
    localparam int N_RAND   = 40;

    typedef struct packed {
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        rd_wen;
        logic        we;
        logic        re;
        logic [2:0]  wb_sel;
        logic [31:0] pc;
        logic [31:0] wdata;
        logic [3:0]  csr_cmd;
        logic [11:0] csr_addr;
        logic [31:0] op1;
    } instr_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [154:0] exe_mem_bus_in;
    logic [120:0] mem_wb_bus_out;
    logic         mem_stall;
    logic         dmem_req;
    logic         dmem_we;
    logic [31:0]  dmem_addr;
    logic [31:0]  dmem_wdata;
    logic         dmem_ready;
    logic [31:0]  dmem_rdata;
    logic         dmem_err;
`ifdef MEM_MISALIGN_CHECK_EN
    logic         misalign_err;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_stage #(.MAX_WAIT(MAX_WAIT), .CNT_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .exe_mem_bus_in (exe_mem_bus_in),
        .mem_wb_bus_out (mem_wb_bus_out),
        .mem_stall      (mem_stall),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_ready     (dmem_ready),
        .dmem_rdata     (dmem_rdata),
        .dmem_err       (dmem_err)
`ifdef MEM_MISALIGN_CHECK_EN
        ,
        .misalign_err   (misalign_err)
`endif
    );

    wire [31:0] o_val  = mem_wb_bus_out[120:89];
    wire [4:0]  o_rd   = mem_wb_bus_out[88:84];
    wire        o_wen  = mem_wb_bus_out[83];
    wire [2:0]  o_sel  = mem_wb_bus_out[82:80];
    wire [31:0] o_pc   = mem_wb_bus_out[79:48];
    wire [47:0] o_csr  = mem_wb_bus_out[47:0];

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // Write-back value chosen by wb_sel, straight from the selection rules.
    function automatic logic [31:0] ref_wb(instr_t t, logic [31:0] rdata);
        if (t.wb_sel == 3'b010)      return rdata;
        else if (t.wb_sel == 3'b011) return t.pc + 32'd4;
        else                         return t.alu;
    endfunction

    function automatic instr_t rand_instr();
        instr_t t;
        int kind;
        kind       = $urandom_range(0, 3);
        t          = '0;
        t.alu      = $urandom;
        t.rd       = 5'($urandom);
        t.rd_wen   = 1'($urandom);
        t.we       = (kind == 1) || (kind == 3);
        t.re       = (kind == 2) || (kind == 3);
        t.wb_sel   = ($urandom_range(0, 2) == 0) ? 3'b010 : 3'($urandom_range(0, 7));
        t.pc       = $urandom;
        t.wdata    = $urandom;
        t.csr_cmd  = 4'($urandom);
        t.csr_addr = 12'($urandom);
        t.op1      = $urandom;
`ifdef MEM_MISALIGN_CHECK_EN
        if (t.we || t.re) t.alu[1:0] = 2'b00;
`endif
        return t;
    endfunction

    task automatic test_reset();
        instr_t t;
        t              = rand_instr();
        t.re           = 1'b1;
        rst_n          = 1'b0;
        exe_mem_bus_in = t;
        dmem_ready     = 1'b1;
        dmem_rdata     = 32'hFFFF_FFFF;
        next_cycle();
        checks++;
        if ({dmem_req, dmem_we, dmem_err, mem_stall} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl got req/we/err/stall=%b exp=0000",
                     {dmem_req, dmem_we, dmem_err, mem_stall});
        end
        checks++;
        if ({dmem_addr, dmem_wdata, mem_wb_bus_out} !== '0) begin
            failures++;
            $display("FAIL reset_data got addr=%h wdata=%h bus=%h exp=0",
                     dmem_addr, dmem_wdata, mem_wb_bus_out);
        end
        exe_mem_bus_in = '0;
        dmem_ready     = 1'b0;
        rst_n          = 1'b1;
        #2;
        checks++;
        if (mem_wb_bus_out !== '0 || dmem_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got bus=%h req=%b exp=0", mem_wb_bus_out, dmem_req);
        end
        next_cycle();
        $display("txn reset done");
    endtask

    task automatic test_load_zero_stall();
        instr_t t;
        t        = '0;
        t.alu    = 32'h100;
        t.re     = 1'b1;
        t.wb_sel = 3'b010;
        t.rd     = 5'd5;
        t.rd_wen = 1'b1;
        t.pc     = 32'h20;
        exe_mem_bus_in = t;
        next_cycle();
        exe_mem_bus_in = '0;
        dmem_ready     = 1'b1;
        dmem_rdata     = 32'hDEAD_BEEF;
        #2;
        checks++;
        if ({dmem_req, dmem_we, mem_stall} !== 3'b100 || dmem_addr !== 32'h100) begin
            failures++;
            $display("FAIL ld0_req got req/we/stall=%b addr=%h exp=100 addr=00000100",
                     {dmem_req, dmem_we, mem_stall}, dmem_addr);
        end
        checks++;
        if (o_val !== 32'hDEAD_BEEF || o_wen !== 1'b1 || o_rd !== 5'd5) begin
            failures++;
            $display("FAIL ld0_wb got val=%h wen=%b rd=%0d exp=deadbeef 1 5", o_val, o_wen, o_rd);
        end
        next_cycle();
        dmem_ready = 1'b0;
        #2;
        checks++;
        if (dmem_req !== 1'b0) begin
            failures++;
            $display("FAIL ld0_after got req=%b exp=0", dmem_req);
        end
        $display("txn load zero-stall addr=%h val=%h", dmem_addr, o_val);
    endtask

    task automatic test_store_stall();
        instr_t t;
        instr_t y;
        t        = '0;
        t.alu    = 32'h204;
        t.we     = 1'b1;
        t.wdata  = 32'h1234_5678;
        t.rd_wen = 1'b1;
        t.pc     = 32'h40;
        y        = '0;
        y.alu    = 32'h55;
        y.wb_sel = 3'b001;
        y.rd_wen = 1'b1;
        y.pc     = 32'h44;
        exe_mem_bus_in = t;
        next_cycle();
        exe_mem_bus_in = y;
        for (int c = 0; c < 4; c++) begin
            dmem_ready = (c == 3);
            #2;
            checks++;
            if ({dmem_req, dmem_we, dmem_err} !== 3'b110 || dmem_addr !== 32'h204 ||
                dmem_wdata !== 32'h1234_5678) begin
                failures++;
                $display("FAIL st_req c=%0d got req/we/err=%b addr=%h wdata=%h exp=110 00000204 12345678",
                         c, {dmem_req, dmem_we, dmem_err}, dmem_addr, dmem_wdata);
            end
            checks++;
            if (mem_stall !== (c < 3) || o_wen !== (c == 3)) begin
                failures++;
                $display("FAIL st_stall c=%0d got stall=%b wen=%b exp=%b %b",
                         c, mem_stall, o_wen, c < 3, c == 3);
            end
            next_cycle();
        end
        dmem_ready     = 1'b0;
        exe_mem_bus_in = '0;
        #2;
        checks++;
        if (o_pc !== 32'h44 || o_val !== 32'h55 || mem_stall !== 1'b0 || dmem_req !== 1'b0) begin
            failures++;
            $display("FAIL st_next got pc=%h val=%h stall=%b req=%b exp=00000044 00000055 0 0",
                     o_pc, o_val, mem_stall, dmem_req);
        end
        next_cycle();
        checks++;
        if (o_pc !== 32'h0) begin
            failures++;
            $display("FAIL st_once got pc=%h exp=00000000", o_pc);
        end
        $display("txn store 3-stall addr=204 wdata=12345678");
    endtask

    task automatic test_timeout();
        instr_t t;
        instr_t y;
        t        = '0;
        t.alu    = 32'h300;
        t.re     = 1'b1;
        t.wb_sel = 3'b010;
        t.rd_wen = 1'b1;
        t.pc     = 32'h80;
        y        = '0;
        y.alu    = 32'd9;
        y.rd_wen = 1'b1;
        y.pc     = 32'h84;
        exe_mem_bus_in = t;
        next_cycle();
        exe_mem_bus_in = y;
        dmem_ready     = 1'b0;
        for (int c = 0; c <= MAX_WAIT; c++) begin
            #2;
            checks++;
            if (c < MAX_WAIT) begin
                if ({dmem_req, mem_stall, dmem_err, o_wen} !== 4'b1100) begin
                    failures++;
                    $display("FAIL to_wait c=%0d got req/stall/err/wen=%b exp=1100",
                             c, {dmem_req, mem_stall, dmem_err, o_wen});
                end
            end else begin
                if ({dmem_req, mem_stall, dmem_err, o_wen} !== 4'b0010) begin
                    failures++;
                    $display("FAIL to_abort got req/stall/err/wen=%b exp=0010",
                             {dmem_req, mem_stall, dmem_err, o_wen});
                end
            end
            next_cycle();
        end
        exe_mem_bus_in = '0;
        #2;
        checks++;
        if (o_pc !== 32'h84 || o_val !== 32'd9 || o_wen !== 1'b1 || dmem_err !== 1'b0) begin
            failures++;
            $display("FAIL to_next got pc=%h val=%h wen=%b err=%b exp=00000084 00000009 1 0",
                     o_pc, o_val, o_wen, dmem_err);
        end
        next_cycle();
        $display("txn load timeout addr=300");
    endtask

    task automatic test_non_mem();
        instr_t a;
        instr_t b;
        a          = '0;
        a.wb_sel   = 3'b011;
        a.pc       = 32'hFFFF_FFFC;
        a.alu      = 32'h1234;
        a.rd_wen   = 1'b1;
        b          = '0;
        b.wb_sel   = 3'b001;
        b.alu      = 32'd7;
        b.pc       = 32'h10;
        b.rd_wen   = 1'b1;
        b.csr_cmd  = 4'hA;
        b.csr_addr = 12'h341;
        b.op1      = 32'hCAFE_F00D;
        exe_mem_bus_in = a;
        next_cycle();
        exe_mem_bus_in = b;
        dmem_ready     = 1'b1;
        #2;
        checks++;
        if (o_val !== 32'h0 || dmem_req !== 1'b0 || mem_stall !== 1'b0 || o_wen !== 1'b1) begin
            failures++;
            $display("FAIL nm_pc got val=%h req=%b stall=%b wen=%b exp=00000000 0 0 1",
                     o_val, dmem_req, mem_stall, o_wen);
        end
        next_cycle();
        exe_mem_bus_in = '0;
        dmem_ready     = 1'b0;
        #2;
        checks++;
        if (o_val !== 32'd7 || dmem_req !== 1'b0 || mem_stall !== 1'b0 || o_sel !== 3'b001) begin
            failures++;
            $display("FAIL nm_alu got val=%h req=%b stall=%b sel=%b exp=00000007 0 0 001",
                     o_val, dmem_req, mem_stall, o_sel);
        end
        checks++;
        if (o_csr !== {4'hA, 12'h341, 32'hCAFE_F00D}) begin
            failures++;
            $display("FAIL nm_csr got %h exp=%h", o_csr, {4'hA, 12'h341, 32'hCAFE_F00D});
        end
        next_cycle();
        $display("txn non-memory pc-wrap and alu");
    endtask

    task automatic test_reset_mid_wait();
        instr_t t;
        t          = '0;
        t.alu      = 32'h400;
        t.re       = 1'b1;
        t.wb_sel   = 3'b010;
        t.rd_wen   = 1'b1;
        t.pc       = 32'hC0;
        t.csr_cmd  = 4'h3;
        t.op1      = 32'h1111_2222;
        exe_mem_bus_in = t;
        next_cycle();
        exe_mem_bus_in = '0;
        dmem_ready     = 1'b0;
        next_cycle();
        #2;
        checks++;
        if (mem_stall !== 1'b1 || dmem_req !== 1'b1) begin
            failures++;
            $display("FAIL rmw_pre got stall=%b req=%b exp=1 1", mem_stall, dmem_req);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (dmem_req !== 1'b0 || mem_wb_bus_out !== '0 || mem_stall !== 1'b0) begin
            failures++;
            $display("FAIL rmw_async got req=%b bus=%h stall=%b exp=0 0 0",
                     dmem_req, mem_wb_bus_out, mem_stall);
        end
        next_cycle();
        rst_n = 1'b1;
        #2;
        checks++;
        if (mem_wb_bus_out !== '0 || dmem_req !== 1'b0) begin
            failures++;
            $display("FAIL rmw_empty got bus=%h req=%b exp=0 0", mem_wb_bus_out, dmem_req);
        end
        // A fresh full timeout shows the FSM and counter restarted from IDLE.
        t.alu          = 32'h500;
        exe_mem_bus_in = t;
        next_cycle();
        exe_mem_bus_in = '0;
        for (int c = 0; c <= MAX_WAIT; c++) begin
            #2;
            checks++;
            if (mem_stall !== (c < MAX_WAIT) || dmem_err !== (c == MAX_WAIT)) begin
                failures++;
                $display("FAIL rmw_idle c=%0d got stall=%b err=%b exp=%b %b",
                         c, mem_stall, dmem_err, c < MAX_WAIT, c == MAX_WAIT);
            end
            next_cycle();
        end
        $display("txn reset mid-wait");
    endtask

`ifdef MEM_MISALIGN_CHECK_EN
    task automatic test_misalign();
        instr_t t;
        t        = '0;
        t.alu    = 32'h102;
        t.re     = 1'b1;
        t.wb_sel = 3'b010;
        t.rd_wen = 1'b1;
        exe_mem_bus_in = t;
        next_cycle();
        exe_mem_bus_in = '0;
        dmem_ready     = 1'b1;
        #2;
        checks++;
        if ({dmem_req, misalign_err, o_wen, mem_stall} !== 4'b0100) begin
            failures++;
            $display("FAIL mis got req/merr/wen/stall=%b exp=0100",
                     {dmem_req, misalign_err, o_wen, mem_stall});
        end
        next_cycle();
        dmem_ready = 1'b0;
        #2;
        checks++;
        if (misalign_err !== 1'b0) begin
            failures++;
            $display("FAIL mis_pulse got merr=%b exp=0", misalign_err);
        end
        $display("txn misaligned load addr=102");
    endtask
`endif

    task automatic test_back_to_back();
        instr_t q[N_RAND];
        int     dly[N_RAND];
        for (int k = 0; k < N_RAND; k++) begin
            q[k]   = rand_instr();
            dly[k] = $urandom_range(0, 6);
        end
        exe_mem_bus_in = q[0];
        next_cycle();
        for (int k = 0; k < N_RAND; k++) begin
            logic        acc;
            logic        aborted;
            int          n;
            int          fail0;
            exe_mem_bus_in = (k + 1 < N_RAND) ? q[k + 1] : '0;
            acc     = q[k].we | q[k].re;
            aborted = acc && (dly[k] > MAX_WAIT);
            n       = acc ? (((dly[k] > MAX_WAIT) ? MAX_WAIT : dly[k]) + 1) : 1;
            fail0   = failures;
            for (int c = 0; c < n; c++) begin
                logic        last;
                logic [31:0] rdata;
                last       = (c == n - 1);
                rdata      = $urandom;
                dmem_rdata = rdata;
                dmem_ready = acc ? (c == dly[k]) : 1'($urandom);
                #2;
                checks++;
                if (dmem_req !== (acc && !(aborted && last)) || mem_stall !== !last ||
                    dmem_err !== (aborted && last)) begin
                    failures++;
                    $display("FAIL rnd_ctrl k=%0d c=%0d got req/stall/err=%b%b%b exp=%b%b%b",
                             k, c, dmem_req, mem_stall, dmem_err,
                             acc && !(aborted && last), !last, aborted && last);
                end
                checks++;
                if (o_wen !== (q[k].rd_wen && last && !aborted) || o_val !== ref_wb(q[k], rdata)) begin
                    failures++;
                    $display("FAIL rnd_wb k=%0d c=%0d got wen=%b val=%h exp=%b %h",
                             k, c, o_wen, o_val, q[k].rd_wen && last && !aborted, ref_wb(q[k], rdata));
                end
                checks++;
                if (o_pc !== q[k].pc || o_rd !== q[k].rd || o_sel !== q[k].wb_sel ||
                    o_csr !== {q[k].csr_cmd, q[k].csr_addr, q[k].op1}) begin
                    failures++;
                    $display("FAIL rnd_pass k=%0d c=%0d got pc=%h rd=%0d sel=%b csr=%h exp=%h %0d %b %h",
                             k, c, o_pc, o_rd, o_sel, o_csr, q[k].pc, q[k].rd, q[k].wb_sel,
                             {q[k].csr_cmd, q[k].csr_addr, q[k].op1});
                end
                if (acc) begin
                    checks++;
                    if (dmem_we !== q[k].we || dmem_addr !== {q[k].alu[31:2], 2'b00} ||
                        dmem_wdata !== q[k].wdata) begin
                        failures++;
                        $display("FAIL rnd_mem k=%0d c=%0d got we=%b addr=%h wdata=%h exp=%b %h %h",
                                 k, c, dmem_we, dmem_addr, dmem_wdata, q[k].we,
                                 {q[k].alu[31:2], 2'b00}, q[k].wdata);
                    end
                end
                next_cycle();
            end
            $display("txn rnd k=%0d we=%b re=%b dly=%0d cycles=%0d abort=%b new_failures=%0d",
                     k, q[k].we, q[k].re, dly[k], n, aborted, failures - fail0);
        end
        dmem_ready = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        exe_mem_bus_in = '0;
        dmem_ready     = 1'b0;
        dmem_rdata     = '0;
        test_reset();
        test_load_zero_stall();
        test_store_stall();
        test_timeout();
        test_non_mem();
        test_reset_mid_wait();
`ifdef MEM_MISALIGN_CHECK_EN
        test_misalign();
`endif
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp=finish");
        $fatal(1, "simulation time limit");
    end

endmodule
